multdiv_writeback: RTL and testbench

- Sits between the multiplier/divider and the register-file write port.
- On issue, captures the destination register of each multdiv operation; on completion, buffers the result in a 2-entry queue.
- Merges queued results with the main pipeline's writeback, giving the pipeline priority.
- Drives the register-file write enable, data and 5-bit write select, which feeds the 5-to-32 write decoder.

---
 rtl/multdiv_writeback_if.sv | 30 +++
 rtl/multdiv_writeback.sv | 160 ++++++++++++++++
 tb/tb_multdiv_writeback.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_writeback_if.sv
// Multdiv writeback bus: multdiv issue/completion, pipeline writeback request
// and the merged register-file write port.
interface multdiv_writeback_if;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_issue_div;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        wb_en;
  logic [4:0]  wb_stream;
  logic [31:0] wb_data;
  logic        md_busy;
  logic        md_stall;

  modport master (
    output md_issue, md_issue_rd, md_issue_div, md_ready, md_result, md_exception,
    output pipe_we, pipe_rd, pipe_data,
    input  wb_en, wb_stream, wb_data, md_busy, md_stall
  );

  modport slave (
    input  md_issue, md_issue_rd, md_issue_div, md_ready, md_result, md_exception,
    input  pipe_we, pipe_rd, pipe_data,
    output wb_en, wb_stream, wb_data, md_busy, md_stall
  );
endinterface

// File: rtl/multdiv_writeback.sv
// Multdiv result writeback: tags in-flight op, queues completed results and
// merges them into the register-file write port behind the main pipeline.

module multdiv_writeback_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr,
  input  logic        kill,
  input  logic [4:0]  wr_rd,
  input  logic [31:0] wr_data,
  output logic        live,
  output logic [4:0]  rd,
  output logic [31:0] data
);
  // A fresh write beats a same-cycle kill: the push is younger than the pipe write.
  always_ff @(posedge clock) begin
    if (reset) begin
      live <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (wr) begin
      live <= 1'b1;
      rd   <= wr_rd;
      data <= wr_data;
    end else if (kill) begin
      live <= 1'b0;
    end
  end
endmodule

module multdiv_writeback #(
  parameter int          DEPTH         = 2,
  parameter logic [31:0] MULT_EXC_CODE = 32'd4,
  parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
  input logic                clock,
  input logic                reset,
  multdiv_writeback_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [4:0] EXC_RD = 5'd30;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t  state, state_nxt;
  logic [4:0] tag_rd;
  logic       tag_div;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic issue_ok, push, pop;
  logic [4:0]  push_rd;
  logic [31:0] push_data;

  logic [DEPTH-1:0]       slot_wr, slot_kill, slot_live;
  logic [DEPTH-1:0][4:0]  slot_rd;
  logic [DEPTH-1:0][31:0] slot_data;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_ok)     state_nxt = BUSY;
      BUSY:    if (bus.md_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Stalling at a full queue means a push never finds it full.
  always_comb begin
    bus.md_busy  = (state == BUSY);
    bus.md_stall = (state == BUSY) || (count == CW'(DEPTH));
    issue_ok     = bus.md_issue && !bus.md_stall;
    push         = (state == BUSY) && bus.md_ready;
    pop          = !bus.pipe_we && (count != '0);
  end

  always_comb begin
    push_rd   = tag_rd;
    push_data = bus.md_result;
    if (bus.md_exception) begin
      push_rd   = EXC_RD;
      push_data = tag_div ? DIV_EXC_CODE : MULT_EXC_CODE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_rd  <= '0;
      tag_div <= 1'b0;
    end else if (issue_ok) begin
      tag_rd  <= bus.md_issue_rd;
      tag_div <= bus.md_issue_div;
    end
  end

  assign tail = head + count[PW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue slots; a pipeline write to the same rd retires the older queued value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_wr[i]   = push && (tail == PW'(i));
    assign slot_kill[i] = bus.pipe_we && (slot_rd[i] == bus.pipe_rd);
    multdiv_writeback_slot u_slot (
      .clock   (clock),
      .reset   (reset),
      .wr      (slot_wr[i]),
      .kill    (slot_kill[i]),
      .wr_rd   (push_rd),
      .wr_data (push_data),
      .live    (slot_live[i]),
      .rd      (slot_rd[i]),
      .data    (slot_data[i])
    );
  end

  // Decoder wants the register number bit-reversed.
  function automatic logic [4:0] rev5(input logic [4:0] r);
    return {r[0], r[1], r[2], r[3], r[4]};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.wb_en     <= 1'b0;
      bus.wb_stream <= '0;
      bus.wb_data   <= '0;
    end else if (bus.pipe_we) begin
      bus.wb_en     <= (bus.pipe_rd != 5'd0);
      bus.wb_stream <= rev5(bus.pipe_rd);
      bus.wb_data   <= bus.pipe_data;
    end else if (pop) begin
      bus.wb_en     <= slot_live[head] && (slot_rd[head] != 5'd0);
      bus.wb_stream <= rev5(slot_rd[head]);
      bus.wb_data   <= slot_data[head];
    end else begin
      bus.wb_en     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multdiv_writeback.sv
// Directed bench for multdiv_writeback: expected writes (value and cycle) are
// queued by the stimulus, and a negedge monitor checks every wb_en against them.
module tb_multdiv_writeback;
  logic clock = 1'b0;
  logic reset;

  multdiv_writeback_if bus();

  multdiv_writeback #(.DEPTH(2), .MULT_EXC_CODE(32'd4), .DIV_EXC_CODE(32'd5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  stream;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [4:0] rev5(input logic [4:0] r);
    logic [4:0] o;
    for (int i = 0; i < 5; i++) o[i] = r[4 - i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] stream, input logic [31:0] data, input int at);
    exp_t e;
    e.stream = stream;
    e.data   = data;
    e.cyc    = at;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic md_op(input logic [4:0] rd, input logic div, input int gap,
                       input logic [31:0] res, input logic exc);
    bus.md_issue     = 1'b1;
    bus.md_issue_rd  = rd;
    bus.md_issue_div = div;
    tick();
    bus.md_issue = 1'b0;
    repeat (gap - 1) tick();
    bus.md_ready     = 1'b1;
    bus.md_result    = res;
    bus.md_exception = exc;
    tick();
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
  endtask

  // Monitor: every asserted write must match the head of the expectation queue.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b0 && bus.wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: stream=%b data=%h at cycle %0d, none expected",
                 bus.wb_stream, bus.wb_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_stream", 32'(bus.wb_stream), 32'(e.stream));
        chk("wb_data",   bus.wb_data,        e.data);
        chk("wb_cycle",  32'(cyc),           32'(e.cyc));
      end
    end
  end

  initial begin
    int b;
    reset            = 1'b1;
    bus.md_issue     = 1'b0;
    bus.md_issue_rd  = '0;
    bus.md_issue_div = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.pipe_we      = 1'b0;
    bus.pipe_rd      = '0;
    bus.pipe_data    = '0;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_wb_en",     32'(bus.wb_en),     32'd0);
    chk("rst_wb_stream", 32'(bus.wb_stream), 32'd0);
    chk("rst_wb_data",   bus.wb_data,        32'd0);
    chk("rst_md_busy",   32'(bus.md_busy),   32'd0);
    chk("rst_md_stall",  32'(bus.md_stall),  32'd0);

    // Multiply rd=5, completion 3 cycles after issue, write 2 cycles later.
    b = cyc;
    expect_wr(5'b10100, 32'h0000_00C8, b + 5);
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd5; bus.md_issue_div = 1'b0;
    tick();
    bus.md_issue = 1'b0;
    chk("busy_t1",  32'(bus.md_busy),  32'd1);
    chk("stall_t1", 32'(bus.md_stall), 32'd1);
    tick();
    tick();
    chk("busy_t3", 32'(bus.md_busy), 32'd1);
    bus.md_ready = 1'b1; bus.md_result = 32'h0000_00C8;
    tick();
    bus.md_ready = 1'b0;
    chk("busy_t4",  32'(bus.md_busy),  32'd0);
    chk("stall_t4", 32'(bus.md_stall), 32'd0);
    tick();
    chk("wb_en_t5", 32'(bus.wb_en), 32'd1);
    tick();

    // Exceptions map to r30 with the divide/multiply code.
    b = cyc;
    expect_wr(5'b01111, 32'd5, b + 3);
    md_op(5'd7, 1'b1, 1, 32'hDEAD_BEEF, 1'b1);
    repeat (2) tick();
    b = cyc;
    expect_wr(5'b01111, 32'd4, b + 3);
    md_op(5'd7, 1'b0, 1, 32'hDEAD_BEEF, 1'b1);
    repeat (2) tick();

    // Pipeline priority: r6 and r8 wait behind four pipeline writes.
    b = cyc;
    expect_wr(rev5(5'd3),  32'h0000_0303, b + 3);
    expect_wr(rev5(5'd9),  32'h0000_0909, b + 4);
    expect_wr(rev5(5'd12), 32'h0000_0C0C, b + 5);
    expect_wr(rev5(5'd1),  32'h0000_0101, b + 6);
    expect_wr(rev5(5'd6),  32'h0000_0606, b + 7);
    expect_wr(rev5(5'd8),  32'h0000_0808, b + 8);
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd6; bus.md_issue_div = 1'b0;
    tick();
    bus.md_issue = 1'b0;
    bus.md_ready = 1'b1; bus.md_result = 32'h0000_0606;
    tick();
    bus.md_ready = 1'b0;
    chk("stall_q1_idle", 32'(bus.md_stall), 32'd0);
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h0000_0303;
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd8;
    tick();
    chk("stall_busy8", 32'(bus.md_stall), 32'd1);
    bus.md_issue = 1'b0;
    bus.pipe_rd = 5'd9; bus.pipe_data = 32'h0000_0909;
    bus.md_ready = 1'b1; bus.md_result = 32'h0000_0808;
    tick();
    bus.md_ready = 1'b0;
    chk("stall_full",  32'(bus.md_stall), 32'd1);
    chk("busy_full",   32'(bus.md_busy),  32'd0);
    bus.pipe_rd = 5'd12; bus.pipe_data = 32'h0000_0C0C;
    tick();
    bus.pipe_rd = 5'd1; bus.pipe_data = 32'h0000_0101;
    tick();
    chk("stall_full2", 32'(bus.md_stall), 32'd1);
    bus.pipe_we = 1'b0;
    tick();
    chk("stall_after_pop", 32'(bus.md_stall), 32'd0);
    repeat (3) tick();

    // Younger pipeline write to r10 invalidates the queued r10 result.
    b = cyc;
    expect_wr(rev5(5'd10), 32'h0000_00AA, b + 3);
    md_op(5'd10, 1'b0, 1, 32'h0000_1234, 1'b0);
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd10; bus.pipe_data = 32'h0000_00AA;
    tick();
    bus.pipe_we = 1'b0;
    tick();
    chk("inval_wb_en",     32'(bus.wb_en),     32'd0);
    chk("inval_wb_stream", 32'(bus.wb_stream), 32'(rev5(5'd10)));
    chk("inval_wb_data",   bus.wb_data,        32'h0000_1234);
    bus.pipe_we = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'h0000_00BB;
    tick();
    bus.pipe_we = 1'b0;
    chk("pipe_r0_wb_en", 32'(bus.wb_en),  32'd0);
    chk("pipe_r0_data",  bus.wb_data,     32'h0000_00BB);
    tick();

    // Multdiv to r0: presented but not enabled.
    md_op(5'd0, 1'b0, 1, 32'h0000_0055, 1'b0);
    tick();
    chk("md_r0_wb_en",  32'(bus.wb_en),     32'd0);
    chk("md_r0_stream", 32'(bus.wb_stream), 32'd0);
    chk("md_r0_data",   bus.wb_data,        32'h0000_0055);
    repeat (2) tick();

    // Reset while busy; the late md_ready must be dropped.
    bus.md_issue = 1'b1; bus.md_issue_rd = 5'd9; bus.md_issue_div = 1'b0;
    tick();
    bus.md_issue = 1'b0;
    chk("rst_mid_busy_pre", 32'(bus.md_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy",  32'(bus.md_busy),  32'd0);
    chk("rst_mid_stall", 32'(bus.md_stall), 32'd0);
    tick();
    bus.md_ready = 1'b1; bus.md_result = 32'h0000_0077;
    tick();
    bus.md_ready = 1'b0;
    repeat (3) tick();
    chk("late_ready_busy",  32'(bus.md_busy),  32'd0);
    chk("late_ready_stall", 32'(bus.md_stall), 32'd0);

    // A fresh op after reset writes alone and on time, so the queue was empty.
    b = cyc;
    expect_wr(rev5(5'd2), 32'h0000_0022, b + 3);
    md_op(5'd2, 1'b0, 1, 32'h0000_0022, 1'b0);
    repeat (4) tick();

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
